// File: rtl/uart_pkg.sv
// Shared UART definitions: default line parameters, frame width and the
// byte-level state encoding used by both the 1-byte receiver and transmitter.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 115200;
  localparam int NBYTES           = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int baud_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_1byte_rx.sv
// 8N1 byte receiver: 2-FF input synchroniser, baud counter and
// IDLE/START/DATA/STOP FSM producing registered rx_done / rx_err strobes.
module uart_1byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err
);

  localparam int BAUD_CNT = baud_cnt(CLK_FREQ, BAUD);
  localparam int CNT_W    = $clog2(BAUD_CNT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_CNT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rxPrev;
  logic             w_rx;
  uart_state_e      r_state;
  uart_state_e      w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_done;
  logic             r_err;
  logic             w_cntClr;
  logic             w_shiftEn;
  logic             w_done;
  logic             w_err;

  assign w_rx    = r_sync2;
  assign rx_data = r_shift;
  assign rx_done = r_done;
  assign rx_err  = r_err;

  // Flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= uart_rx;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bitIdx <= 3'd0;
      r_shift  <= 8'h00;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntClr ? '0 : r_cnt + 1'b1;
      r_done  <= w_done;
      r_err   <= w_err;
      if (w_shiftEn) begin
        r_shift  <= {w_rx, r_shift[7:1]};
        r_bitIdx <= r_bitIdx + 3'd1;
      end
    end
  end

  // STOP returns to IDLE at the mid-stop sample so an immediately following
  // start bit is still seen as a fresh falling edge.
  always_comb begin
    w_nextState = r_state;
    w_cntClr    = 1'b0;
    w_shiftEn   = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cntClr = 1'b1;
        if (r_rxPrev && !w_rx) w_nextState = ST_START;
      end
      ST_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cntClr    = 1'b1;
          w_nextState = w_rx ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cntClr  = 1'b1;
          w_shiftEn = 1'b1;
          if (r_bitIdx == 3'd7) w_nextState = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cntClr    = 1'b1;
          w_nextState = ST_IDLE;
          w_done      = w_rx;
          w_err       = !w_rx;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_6byte_rx.sv
// Collects six UART bytes (first byte in the low bits) into one 48-bit word,
// discarding partial frames on stop-bit errors or an inter-byte timeout.
module uart_6byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic [8*NBYTES-1:0]   uart_data_out,
  output logic                  recv_done,
  output logic                  frame_err
);

  localparam int BAUD_CNT     = baud_cnt(CLK_FREQ, BAUD);
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * BAUD_CNT;
  localparam int GAP_W        = $clog2(TIMEOUT_CLKS + 1);
  // Expiry is decoded two counts early so frame_err rises exactly
  // TIMEOUT_CLKS cycles after the last rx_done strobe.
  localparam logic [GAP_W-1:0] GAP_EXPIRE = GAP_W'(TIMEOUT_CLKS - 2);
  localparam logic [2:0]       LAST_IDX   = 3'(NBYTES - 1);

  logic [7:0]          w_rxData;
  logic                w_rxDone;
  logic                w_rxErr;
  logic                w_timeout;
  logic [8*NBYTES-1:0] w_assembled;
  logic [2:0]          r_idx;
  logic [8*NBYTES-1:0] r_staging;
  logic [GAP_W-1:0]    r_gap;
  logic [8*NBYTES-1:0] r_dataOut;
  logic                r_recvDone;
  logic                r_frameErr;

  uart_1byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byteRx (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .rx_data (w_rxData),
    .rx_done (w_rxDone),
    .rx_err  (w_rxErr)
  );

  assign uart_data_out = r_dataOut;
  assign recv_done     = r_recvDone;
  assign frame_err     = r_frameErr;
  assign w_timeout     = (r_idx != 3'd0) && (r_gap == GAP_EXPIRE);

  always_comb begin
    w_assembled = r_staging;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == 3'(i)) w_assembled[8*i +: 8] = w_rxData;
    end
  end

  // Byte events take priority over timeout; the gap counter only runs mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= 3'd0;
      r_staging  <= '0;
      r_gap      <= '0;
      r_dataOut  <= '0;
      r_recvDone <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_recvDone <= 1'b0;
      r_frameErr <= 1'b0;
      if (w_rxErr) begin
        r_idx      <= 3'd0;
        r_staging  <= '0;
        r_gap      <= '0;
        r_frameErr <= 1'b1;
      end else if (w_rxDone) begin
        r_gap     <= '0;
        r_staging <= w_assembled;
        if (r_idx == LAST_IDX) begin
          r_idx      <= 3'd0;
          r_dataOut  <= w_assembled;
          r_recvDone <= 1'b1;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end else if (w_timeout) begin
        r_idx      <= 3'd0;
        r_staging  <= '0;
        r_gap      <= '0;
        r_frameErr <= 1'b1;
      end else if (r_idx != 3'd0) begin
        r_gap <= r_gap + 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_6byte_rx.md
# uart_6byte_rx

Receive-side counterpart of the 6-byte UART transmit path. It deserialises an 8N1 UART stream from `uart_rx`, collects six consecutive bytes LSB-byte-first, and presents them as one 48-bit word with a single-cycle `recv_done` pulse. It sits between the board RX pin and the CORDIC command/operand logic, and accepts the byte order the 6-byte transmitter produces.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate. `BAUD_CNT = CLK_FREQ/BAUD` (integer division) = 434 clocks per bit.
- `TIMEOUT_BITS`, default 20: maximum inter-byte gap, in bit periods, inside one 6-byte frame.
- `clk` in 1: system clock. One clock domain; all logic on its rising edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `uart_rx` in 1: asynchronous serial input. Idles high.
- `uart_data_out` out 48: last complete word. Byte 0 (first received) is in [7:0]; byte 5 is in [47:40].
- `recv_done` out 1: one-cycle pulse when `uart_data_out` is updated.
- `frame_err` out 1: one-cycle pulse when a partial frame is discarded.

## Operation
- **Input sync:** `uart_rx` passes through a 2-FF synchroniser. Both flops reset to 1. All logic uses the synchronised signal.
- **Byte receiver states:** IDLE, START, DATA, STOP.
  - IDLE: on a 1→0 edge, go to START and clear the baud counter.
  - START: at count `BAUD_CNT/2 - 1`, sample the line. If low, go to DATA. If high (glitch or false start), return to IDLE with no output.
  - DATA: sample every `BAUD_CNT` clocks, 8 bits, LSB first, into a shift register.
  - STOP: sample one `BAUD_CNT` later.
    - Stop = 1: pulse `rx_done` with `rx_data` valid.
    - Stop = 0: pulse `rx_err`.
    - Either way, return to IDLE in the same cycle, so a start bit immediately after the mid-stop sample is caught.
- **Frame assembler:**
  - Holds a 3-bit byte index (0..5) and a 48-bit staging register.
  - On `rx_done`, write `rx_data` into staging[8*idx +: 8].
  - If idx < 5, increment idx. If idx == 5, copy the assembled word to `uart_data_out`, pulse `recv_done`, and set idx to 0.
- **Timeout:**
  - While idx != 0, a gap counter counts clocks since the last `rx_done`.
  - The counter clears on every `rx_done`.
  - When it reaches `TIMEOUT_BITS*BAUD_CNT` (8680 at defaults): idx → 0, staging discarded, `frame_err` pulses.
  - The counter does not run while idx == 0.
- **Stop-bit error:** `rx_err` in any byte position sets idx to 0, discards staging and pulses `frame_err`. The next good byte becomes byte 0.
- **Output hold:** `uart_data_out` changes only on a completed frame. Discarded partials never reach it.
- **Simultaneous events:** `rx_done`/`rx_err` and timeout expiry in the same cycle cannot be coincident by construction, because `rx_done` clears the gap counter. If an implementation allows it, the byte event wins and the timeout is ignored.
- **Reset:** reset mid-byte or mid-frame aborts everything. Reset values:
  - byte receiver → IDLE
  - idx = 0, staging = 0, gap counter = 0
  - `uart_data_out` = 48'h0
  - `recv_done` = 0, `frame_err` = 0

## Timing
- **Sample point:** start-bit validation happens `BAUD_CNT/2` clocks after the synchronised falling edge (synchroniser delay is 2 clocks). Data bits are then sampled mid-bit.
- **Byte strobe:** `rx_done`/`rx_err` is registered. It is high for exactly 1 cycle, the cycle after the mid-stop sample.
- **Frame latency:** `recv_done` and the new `uart_data_out` appear on the clock edge after byte 5's `rx_done`, i.e. 1 cycle later. `recv_done` is exactly 1 cycle wide.
- **Error strobe:** `frame_err` is high 1 cycle after the `rx_err` or timeout condition, and exactly 1 cycle wide.
- **Back-to-back frames:** sustained with zero idle between stop and start bits, at any byte and frame boundary.
- **Clock tolerance:** correct reception with up to ±2 % baud mismatch.

## Structure
- **Shared package `uart_pkg`:**
  - default `CLK_FREQ` and `BAUD`
  - `NBYTES = 6`
  - a `baud_cnt(clk_freq, baud)` constant function
  - state encodings for the byte receiver, shared with `uart_1byte_tx`
- **Sub-module `uart_1byte_rx`:**
  - contains the synchroniser, baud counter and IDLE/START/DATA/STOP FSM
  - outputs: `rx_data[7:0]`, `rx_done`, `rx_err`
  - mirrors `uart_1byte_tx`
- **`uart_6byte_rx` (this block):** contains only the assembler, the timeout counter and the output registers.

## Test plan
- **Basic frame:** bytes 66 55 44 33 22 11 at 115200 → one `recv_done` pulse; `uart_data_out` = 48'h112233445566; `frame_err` never asserted.
- **Glitch rejection:** 100-cycle low glitch on an idle line, then frame AA..FF → glitch produces no byte; `uart_data_out` = 48'hFFEEDDCCBBAA.
- **Stop-bit error:** byte 3 sent with stop = 0 → `frame_err` pulse; no `recv_done`; `uart_data_out` keeps its prior value. A following clean frame 01..06 → 48'h060504030201.
- **Inter-byte timeout:** 2 bytes, then 25 bit periods idle → `frame_err` exactly 8680 clocks after byte 2's `rx_done`. A following clean 6-byte frame is received correctly.
- **Back-to-back frames:** two frames with zero idle gap and ±2 % baud offset → two `recv_done` pulses with the correct values.
- **Reset mid-frame:** `rst_n` low for 1 cycle during byte 4 → all outputs at reset values. The next full frame is received correctly.
